// File: rtl/reg_decoder_pkg.sv
// Shared types and helpers for reg_decoder: state encodings, one-hot
// expansion and hold-timer width sizing.
package reg_decoder_pkg;

  localparam int unsigned MAX_SEL_W = 8;
  localparam int unsigned MAX_OUT_W = 1 << MAX_SEL_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_e;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_HOLD = 2'd1;
  localparam state_t ST_SCAN = 2'd2;

  // Callers truncate the result to their own output width.
  function automatic logic [MAX_OUT_W-1:0] onehot(input int unsigned idx);
    return MAX_OUT_W'(1) << idx;
  endfunction

  // Counter must hold hold_cyc-1; never narrower than one bit.
  function automatic int unsigned timer_w(input int unsigned hold_cyc);
    return (hold_cyc < 32'd2) ? 32'd1 : 32'($clog2(hold_cyc + 32'd1));
  endfunction

endpackage

// File: rtl/reg_decoder_hold.sv
// hold_timer: loadable down-counter with a zero flag, shared by the
// HOLD and SCAN phases of reg_decoder.
module hold_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         dec,
  output logic         zero_c
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load has priority; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (ld) begin
        cnt_d = ld_val;
      end else if (dec && (cnt_q != '0)) begin
        cnt_d = cnt_q - W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/reg_decoder.sv
// reg_decoder: registered binary-to-one-hot decoder with load handshake
// and timed pulse. Optional walking scan mode enabled by DEC_SCAN_EN.
module reg_decoder
  import reg_decoder_pkg::*;
#(
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned HOLD_CYC = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                load,
  input  logic [SEL_W-1:0]    sel,
`ifdef DEC_SCAN_EN
  input  logic                scan,
`endif
  output logic                ready,
  output logic [(1<<SEL_W)-1:0] q,
  output logic                busy
);

  localparam int unsigned OUT_W   = 1 << SEL_W;
  localparam int unsigned TMR_W   = timer_w(HOLD_CYC);
  localparam int unsigned HOLD_LD = (HOLD_CYC > 0) ? HOLD_CYC - 1 : 0;
  localparam logic        HOLD_FOREVER = (HOLD_CYC == 0);
`ifdef DEC_SCAN_EN
  localparam int unsigned STEP_LD = (HOLD_CYC > 1) ? HOLD_CYC - 1 : 0;
`endif

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   q_q, q_d;
  logic               tmr_ld;
  logic [TMR_W-1:0]   tmr_ld_val;
  logic               tmr_dec;
  logic               tmr_zero_c;
`ifdef DEC_SCAN_EN
  logic [SEL_W-1:0]   idx_q, idx_d;
`endif

  hold_timer #(
    .W (TMR_W)
  ) u_hold_timer (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .ld     (tmr_ld),
    .ld_val (tmr_ld_val),
    .dec    (tmr_dec),
    .zero_c (tmr_zero_c)
  );

  // Next-state logic; with en low every register keeps its value.
  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    tmr_ld     = 1'b0;
    tmr_ld_val = TMR_W'(HOLD_LD);
    tmr_dec    = 1'b0;
`ifdef DEC_SCAN_EN
    idx_d      = idx_q;
`endif
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            q_d     = OUT_W'(onehot(32'(sel)));
            tmr_ld  = 1'b1;
            state_d = ST_HOLD;
          end
`ifdef DEC_SCAN_EN
          else if (scan) begin
            q_d        = OUT_W'(onehot(32'd0));
            idx_d      = '0;
            tmr_ld     = 1'b1;
            tmr_ld_val = TMR_W'(STEP_LD);
            state_d    = ST_SCAN;
          end
`endif
        end
        ST_HOLD: begin
          if (HOLD_FOREVER) begin
            if (load) begin
              q_d = OUT_W'(onehot(32'(sel)));
            end
          end else if (tmr_zero_c) begin
            q_d     = '0;
            state_d = ST_IDLE;
          end else begin
            tmr_dec = 1'b1;
          end
        end
`ifdef DEC_SCAN_EN
        ST_SCAN: begin
          if (!tmr_zero_c) begin
            tmr_dec = 1'b1;
          end else if (idx_q == SEL_W'(OUT_W - 1)) begin
            q_d     = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d      = idx_q + SEL_W'(1);
            q_d        = OUT_W'(onehot(32'(idx_d)));
            tmr_ld     = 1'b1;
            tmr_ld_val = TMR_W'(STEP_LD);
          end
        end
`endif
        default: begin
          q_d     = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
`ifdef DEC_SCAN_EN
      idx_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
`ifdef DEC_SCAN_EN
      idx_q   <= idx_d;
`endif
    end
  end

  assign ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && HOLD_FOREVER);
  assign q     = en ? q_q : '0;
  assign busy  = (q_q != '0);

endmodule

// File: tb/tb_reg_decoder.sv
// Directed bench for reg_decoder: timed hold (HOLD_CYC=3), hold-until-load
// (HOLD_CYC=0) and, with DEC_SCAN_EN, the walking scan (HOLD_CYC=2).
module tb_reg_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       scan_off;
  logic       en3, load3, ready3, busy3;
  logic [1:0] sel3;
  logic [3:0] q3;
  logic       en0, load0, ready0, busy0;
  logic [1:0] sel0;
  logic [3:0] q0;

  int total = 0;
  int bad   = 0;

  reg_decoder #(.SEL_W(2), .HOLD_CYC(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .en    (en3),
    .load  (load3),
    .sel   (sel3),
`ifdef DEC_SCAN_EN
    .scan  (scan_off),
`endif
    .ready (ready3),
    .q     (q3),
    .busy  (busy3)
  );

  reg_decoder #(.SEL_W(2), .HOLD_CYC(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .en    (en0),
    .load  (load0),
    .sel   (sel0),
`ifdef DEC_SCAN_EN
    .scan  (scan_off),
`endif
    .ready (ready0),
    .q     (q0),
    .busy  (busy0)
  );

`ifdef DEC_SCAN_EN
  logic       en2, load2, scan2, ready2, busy2;
  logic [1:0] sel2;
  logic [3:0] q2;

  reg_decoder #(.SEL_W(2), .HOLD_CYC(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .en    (en2),
    .load  (load2),
    .sel   (sel2),
    .scan  (scan2),
    .ready (ready2),
    .q     (q2),
    .busy  (busy2)
  );
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] scan_exp [9];
    scan_exp = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100,
                 4'b1000, 4'b1000, 4'b0000};

    reset = 1'b1; scan_off = 1'b0;
    en3 = 1'b1; load3 = 1'b0; sel3 = 2'd0;
    en0 = 1'b1; load0 = 1'b0; sel0 = 2'd0;
`ifdef DEC_SCAN_EN
    en2 = 1'b1; load2 = 1'b0; sel2 = 2'd0; scan2 = 1'b0;
`endif
    step();
    step();
    reset = 1'b0;

    // Reset state
    chk("rst_q3",     32'(q3),     32'h0);
    chk("rst_busy3",  32'(busy3),  32'h0);
    chk("rst_ready3", 32'(ready3), 32'h1);
    chk("rst_q0",     32'(q0),     32'h0);
    chk("rst_ready0", 32'(ready0), 32'h1);

    // Single pulse sel=2, plus a load during HOLD that must be dropped
    load3 = 1'b1; sel3 = 2'd2;
    step();
    chk("p_q_e0",     32'(q3),     32'h4);
    chk("p_ready_e0", 32'(ready3), 32'h0);
    chk("p_busy_e0",  32'(busy3),  32'h1);
    sel3 = 2'd3;
    step();
    load3 = 1'b0;
    chk("p_q_e1",     32'(q3),     32'h4);
    chk("p_ready_e1", 32'(ready3), 32'h0);
    step();
    chk("p_q_e2",     32'(q3),     32'h4);
    step();
    chk("p_q_e3",     32'(q3),     32'h0);
    chk("p_ready_e3", 32'(ready3), 32'h1);
    chk("p_busy_e3",  32'(busy3),  32'h0);
    step();
    chk("p_noqueue",  32'(q3),     32'h0);

    // Back-to-back sweep of every select with load held high
    load3 = 1'b1; sel3 = 2'd0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("sw%0d_on", k), 32'(q3), 32'h1 << k);
      sel3 = 2'(k + 1);
      step();
      chk($sformatf("sw%0d_mid", k), 32'(q3), 32'h1 << k);
      step();
      chk($sformatf("sw%0d_end", k), 32'(q3), 32'h1 << k);
      step();
      chk($sformatf("sw%0d_gap", k), 32'(q3), 32'h0);
      chk($sformatf("sw%0d_rdy", k), 32'(ready3), 32'h1);
    end
    load3 = 1'b0;
    step();

    // Enable dropped for two edges mid-pulse
    load3 = 1'b1; sel3 = 2'd0;
    step();
    load3 = 1'b0;
    chk("en_q_e0", 32'(q3), 32'h1);
    step();
    chk("en_q_e1", 32'(q3), 32'h1);
    en3 = 1'b0;
    #1;
    chk("en_q_low",    32'(q3),    32'h0);
    step();
    chk("en_q_frz1",   32'(q3),    32'h0);
    step();
    chk("en_q_frz2",   32'(q3),    32'h0);
    chk("en_busy_frz", 32'(busy3), 32'h1);
    chk("en_rdy_frz",  32'(ready3), 32'h0);
    en3 = 1'b1;
    #1;
    chk("en_q_resume", 32'(q3), 32'h1);
    step();
    chk("en_q_e4", 32'(q3), 32'h1);
    step();
    chk("en_q_e5", 32'(q3), 32'h0);
    chk("en_rdy_e5", 32'(ready3), 32'h1);

    // HOLD_CYC=0: replacement without a gap, ready stays high
    load0 = 1'b1; sel0 = 2'd1;
    step();
    load0 = 1'b0;
    chk("h0_q_a",   32'(q0),     32'h2);
    chk("h0_rdy_a", 32'(ready0), 32'h1);
    step();
    chk("h0_q_b",   32'(q0),     32'h2);
    chk("h0_rdy_b", 32'(ready0), 32'h1);
    load0 = 1'b1; sel0 = 2'd3;
    step();
    load0 = 1'b0;
    chk("h0_q_c",   32'(q0),     32'h8);
    step();
    chk("h0_q_d",    32'(q0),    32'h8);
    chk("h0_busy_d", 32'(busy0), 32'h1);
    chk("h0_rdy_d",  32'(ready0), 32'h1);

    // Async reset between edges mid-HOLD
    load3 = 1'b1; sel3 = 2'd1;
    step();
    load3 = 1'b0;
    chk("ar_q_pre", 32'(q3), 32'h2);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_q",     32'(q3),     32'h0);
    chk("ar_busy",  32'(busy3),  32'h0);
    chk("ar_ready", 32'(ready3), 32'h1);
    chk("ar_q0",    32'(q0),     32'h0);
    step();
    reset = 1'b0;
    step();
    chk("ar_q_after", 32'(q3), 32'h0);

`ifdef DEC_SCAN_EN
    // Walking scan with a concurrent load that must be ignored
    scan2 = 1'b1;
    step();
    scan2 = 1'b0; load2 = 1'b1; sel2 = 2'd3;
    chk("sc_0", 32'(q2), 32'(scan_exp[0]));
    chk("sc_rdy", 32'(ready2), 32'h0);
    for (int i = 1; i < 9; i++) begin
      if (i == 8) load2 = 1'b0;
      step();
      chk($sformatf("sc_%0d", i), 32'(q2), 32'(scan_exp[i]));
    end
    chk("sc_rdy_end", 32'(ready2), 32'h1);

    // Load and scan together in IDLE: load wins
    load2 = 1'b1; scan2 = 1'b1; sel2 = 2'd2;
    step();
    load2 = 1'b0; scan2 = 1'b0;
    chk("ls_q", 32'(q2), 32'h4);
    step();
    chk("ls_q2", 32'(q2), 32'h4);
    step();
    chk("ls_q3", 32'(q2), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
